cdc_hs_rx: RTL and testbench
============================

CDC_HS_RX -- requirements
Module: cdc_hs_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the payload width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, minimum 2, giving the flop count of the request synchronizer.
REQ-003 SHALL have port clk_b, input, 1, the single receive-domain clock; all flops are rising-edge clk_b.
REQ-004 SHALL have port rst_b, input, 1, the reset; asynchronous assert, active-high; the block has one clock and this one reset.
REQ-005 SHALL have port req_tgl_a, input, 1, the request toggle from the clk_a-domain transmitter; each level change is one transfer request.
REQ-006 SHALL have port data_a, input, DATA_W, the payload, held stable by the transmitter from its req toggle until it sees the matching ack toggle.
REQ-007 SHALL have port ack_tgl_b, output, 1, the acknowledge toggle returned to the transmitter, registered.
REQ-008 SHALL have port out_valid, output, 1, meaning out_data holds an unconsumed word.
REQ-009 SHALL have port out_data, output, DATA_W, the captured payload, registered.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer accepts the word this cycle.
REQ-011 SHALL have port xfer_cnt, output, 16, the count of completed transfers.
REQ-012 SHALL have port err_b, output, 1, a sticky protocol-violation flag.

Function
REQ-013 SHALL pass req_tgl_a through a SYNC_STAGES-deep flop chain to give req_s; no other logic SHALL sample req_tgl_a.
REQ-014 SHALL keep register req_seen; new_req is defined as req_s != req_seen.
REQ-015 SHALL implement a two-state FSM: IDLE and HOLD.
REQ-016 In IDLE with new_req, the block SHALL on the same edge load out_data <= data_a, set req_seen <= req_s and out_valid <= 1, and enter HOLD.
REQ-017 In IDLE without new_req, all registers SHALL hold and out_valid SHALL be 0.
REQ-018 In HOLD, out_valid SHALL be 1 and out_data SHALL not change.
REQ-019 In HOLD with out_ready=1, the block SHALL on that edge clear out_valid, invert ack_tgl_b, increment xfer_cnt, and return to IDLE.
REQ-020 data_a SHALL be sampled only on the REQ-016 capture edge, never through a synchronizer; its stability is guaranteed by the handshake.
REQ-021 Latency: out_valid SHALL rise on the (SYNC_STAGES+1)th rising clk_b edge after the first edge that samples the new req_tgl_a level (edge 3 for the default).
REQ-022 out_ready=1 in IDLE SHALL have no effect.
REQ-023 Back-to-back: a new_req that is already pending on the HOLD->IDLE edge SHALL be captured on the next edge; there is no extra idle cycle beyond that.
REQ-024 In HOLD, if req_s != req_seen (transmitter toggled before ack), the block SHALL set err_b=1 and not capture; the pending toggle SHALL be serviced as a normal request after return to IDLE.
REQ-025 err_b SHALL clear only on rst_b.
REQ-026 xfer_cnt SHALL wrap 0xFFFF -> 0x0000 without a flag.

Reset
REQ-027 While rst_b=1, the sync chain, req_seen, ack_tgl_b, out_valid, out_data, xfer_cnt and err_b SHALL be 0, and the state SHALL be IDLE.
REQ-028 Reset asserted in HOLD SHALL discard the held word and SHALL not toggle ack_tgl_b.
REQ-029 If req_tgl_a=1 when rst_b releases, it SHALL be treated as a new request after synchronization; system-level practice is to reset both ends together.

Verification
REQ-030 Reset, data_a=0xA5, toggle req_tgl_a 0->1, out_ready=1 -> out_valid=1 with out_data=0xA5 on edge 3; ack_tgl_b=1 and xfer_cnt=1 one edge later.
REQ-031 out_ready=0 for 10 cycles after capture -> out_valid and out_data stay stable and ack_tgl_b does not change; ack toggles on the edge after out_ready rises.
REQ-032 Four transfers 0x01..0x04, each with the next req toggle sent on seeing ack -> four words delivered in order, xfer_cnt=4, ack_tgl_b=0, err_b=0.
REQ-033 Second req toggle while in HOLD -> err_b=1 and stays 1; the first word is unchanged; after acceptance the second request is captured.
REQ-034 rst_b pulsed while in HOLD -> all outputs 0 in the same cycle (asynchronous), ack not toggled, state IDLE.
REQ-035 Preload xfer_cnt near 0xFFFF (force) and complete 2 transfers -> count wraps through 0x0000 to 0x0001.

Source files
------------

// File: rtl/cdc_hs_rx.sv
// Receive side of a toggle-handshake clock-domain crossing: synchronizes the request toggle,
// captures the held payload, presents it valid/ready and returns an acknowledge toggle.
module cdc_hs_rx #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_b,
    input  logic              rst_b,
    input  logic              req_tgl_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              ack_tgl_b,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [15:0]       xfer_cnt,
    output logic              err_b
);

    localparam int unsigned CNT_W = 16;

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("cdc_hs_rx: SYNC_STAGES must be at least 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_seen_q;
    logic                   ack_q;
    logic                   valid_q;
    logic [DATA_W-1:0]      data_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   err_q;

    logic req_s;
    logic new_req;
    logic accept;

    assign req_s   = sync_q[SYNC_STAGES-1];
    assign new_req = (req_s != req_seen_q);
    assign accept  = (state_q == HOLD) && out_ready;
    assign cnt_d   = cnt_q + CNT_W'(accept);

    // data_a is only sampled on the capture edge; the handshake keeps it stable there.
    always_ff @(posedge clk_b or posedge rst_b) begin
        if (rst_b) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            req_seen_q <= 1'b0;
            ack_q      <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl_a};
            cnt_q  <= cnt_d;
            case (state_q)
                IDLE: begin
                    if (new_req) begin
                        data_q     <= data_a;
                        req_seen_q <= req_s;
                        valid_q    <= 1'b1;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    // An early toggle is flagged but left pending for service after return to IDLE.
                    if (new_req) begin
                        err_q <= 1'b1;
                    end
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        ack_q   <= ~ack_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_tgl_b = ack_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign xfer_cnt  = cnt_q;
    assign err_b     = err_q;

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Directed bench for cdc_hs_rx: table-driven transfers plus early-toggle, reset-in-HOLD and counter wrap sequences.
module tb_cdc_hs_rx;

    logic        clk_b;
    logic        rst_b;
    logic        req_tgl_a;
    logic [7:0]  data_a;
    logic        ack_tgl_b;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [15:0] xfer_cnt;
    logic        err_b;

    int n_chk  = 0;
    int n_fail = 0;

    cdc_hs_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk_b     (clk_b),
        .rst_b     (rst_b),
        .req_tgl_a (req_tgl_a),
        .data_a    (data_a),
        .ack_tgl_b (ack_tgl_b),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt),
        .err_b     (err_b)
    );

    initial clk_b = 1'b0;
    always #5 clk_b = ~clk_b;

    typedef struct {
        logic        rst_before;
        logic [7:0]  data;
        int unsigned wait_cyc;
        logic        exp_ack;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_b);
        #1;
    endtask

    task automatic do_reset();
        rst_b     = 1'b1;
        req_tgl_a = 1'b0;
        out_ready = 1'b0;
        data_a    = 8'h00;
        tick();
        tick();
        rst_b = 1'b0;
    endtask

    // Wait for out_valid, returning the number of edges taken (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 20);
    endtask

    task automatic do_xfer(input logic [7:0] d, input int unsigned wt,
                           input logic exp_ack, input logic [15:0] exp_cnt);
        int   n;
        logic ack0;
        ack0      = ack_tgl_b;
        data_a    = d;
        req_tgl_a = ~req_tgl_a;
        wait_valid(n);
        chk("latency", 32'(n), 32'd3);
        chk("cap_data", 32'(out_data), 32'(d));
        for (int i = 0; i < int'(wt); i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(d));
            chk("hold_ack", 32'(ack_tgl_b), 32'(ack0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("acc_valid", 32'(out_valid), 32'd0);
        chk("acc_ack", 32'(ack_tgl_b), 32'(exp_ack));
        chk("acc_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b1, 8'hA5, 0,  1'b1, 16'd1};
        vecs[1] = '{1'b0, 8'h3C, 10, 1'b0, 16'd2};
        vecs[2] = '{1'b0, 8'hFF, 1,  1'b1, 16'd3};
        vecs[3] = '{1'b0, 8'h00, 2,  1'b0, 16'd4};
        vecs[4] = '{1'b1, 8'h01, 0,  1'b1, 16'd1};
        vecs[5] = '{1'b0, 8'h02, 0,  1'b0, 16'd2};
        vecs[6] = '{1'b0, 8'h03, 0,  1'b1, 16'd3};
        vecs[7] = '{1'b0, 8'h04, 0,  1'b0, 16'd4};

        // Reset state and out_ready asserted while idle.
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ack", 32'(ack_tgl_b), 32'd0);
        chk("rst_cnt", 32'(xfer_cnt), 32'd0);
        chk("rst_err", 32'(err_b), 32'd0);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        chk("idle_ready_cnt", 32'(xfer_cnt), 32'd0);
        chk("idle_ready_ack", 32'(ack_tgl_b), 32'd0);
        chk("idle_ready_valid", 32'(out_valid), 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            do_xfer(vecs[i].data, vecs[i].wait_cyc, vecs[i].exp_ack, vecs[i].exp_cnt);
        end
        chk("seq4_cnt", 32'(xfer_cnt), 32'd4);
        chk("seq4_ack", 32'(ack_tgl_b), 32'd0);
        chk("seq4_err", 32'(err_b), 32'd0);

        // Early toggle while holding: flagged, first word kept, second serviced back-to-back.
        do_reset();
        data_a    = 8'h11;
        req_tgl_a = 1'b1;
        wait_valid(n);
        chk("err_first_lat", 32'(n), 32'd3);
        data_a    = 8'h22;
        req_tgl_a = 1'b0;
        tick();
        tick();
        tick();
        chk("err_set", 32'(err_b), 32'd1);
        chk("err_keep_data", 32'(out_data), 32'h11);
        chk("err_keep_valid", 32'(out_valid), 32'd1);
        tick();
        tick();
        chk("err_sticky", 32'(err_b), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("err_acc1_valid", 32'(out_valid), 32'd0);
        chk("err_acc1_ack", 32'(ack_tgl_b), 32'd1);
        chk("err_acc1_cnt", 32'(xfer_cnt), 32'd1);
        tick();
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_data", 32'(out_data), 32'h22);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("err_acc2_ack", 32'(ack_tgl_b), 32'd0);
        chk("err_acc2_cnt", 32'(xfer_cnt), 32'd2);
        chk("err_still", 32'(err_b), 32'd1);

        // Reset while holding, then a high req level at release is a new request.
        do_reset();
        data_a    = 8'h5A;
        req_tgl_a = 1'b1;
        wait_valid(n);
        chk("rh_valid_pre", 32'(out_valid), 32'd1);
        rst_b = 1'b1;
        #1;
        chk("rh_valid", 32'(out_valid), 32'd0);
        chk("rh_data", 32'(out_data), 32'd0);
        chk("rh_ack", 32'(ack_tgl_b), 32'd0);
        chk("rh_cnt", 32'(xfer_cnt), 32'd0);
        chk("rh_err", 32'(err_b), 32'd0);
        tick();
        rst_b  = 1'b0;
        data_a = 8'h6B;
        wait_valid(n);
        chk("rel_lat", 32'(n), 32'd3);
        chk("rel_data", 32'(out_data), 32'h6B);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("rel_ack", 32'(ack_tgl_b), 32'd1);
        chk("rel_cnt", 32'(xfer_cnt), 32'd1);

        // Counter wrap from a preloaded value.
        force dut.cnt_q = 16'hFFFF;
        tick();
        release dut.cnt_q;
        tick();
        chk("wrap_preload", 32'(xfer_cnt), 32'hFFFF);
        do_xfer(8'h77, 0, 1'b0, 16'h0000);
        do_xfer(8'h88, 0, 1'b1, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
